// File: rtl/dccm_port_arb_pkg.sv
// Shared types for the DCCM port arbiter: read-return owner and arbitration state.
package dccm_pkg;

   localparam int unsigned DCCM_AW = 16;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_LSU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

   typedef enum logic {
      ST_LSU_PRI   = 1'b0,
      ST_DMA_FORCE = 1'b1
   } arb_state_e;

endpackage

// File: rtl/dccm_port_arb_if.sv
// LSU, DMA and SRAM-side signals of the DCCM port arbiter.
// slave = arbiter view, master = requester/SRAM environment view.
interface dccm_port_arb_if #(
   parameter int unsigned AW = dccm_pkg::DCCM_AW
) ();

   logic          lsu_rd_en_i;
   logic          lsu_wr_en_i;
   logic [31:0]   lsu_addr_i;
   logic [31:0]   lsu_wdata_i;
   logic [3:0]    lsu_be_i;
   logic          lsu_stall_o;
   logic [31:0]   lsu_rdata_o;

   logic          dma_req_i;
   logic          dma_we_i;
   logic [31:0]   dma_addr_i;
   logic [31:0]   dma_wdata_i;
   logic [3:0]    dma_be_i;
   logic          dma_gnt_o;
   logic          dma_rvalid_o;
   logic [31:0]   dma_rdata_o;

   logic          dccm_en_o;
   logic          dccm_we_o;
   logic [AW-1:0] dccm_addr_o;
   logic [31:0]   dccm_wdata_o;
   logic [3:0]    dccm_be_o;
   logic [31:0]   dccm_rdata_i;

   modport slave (
      input  lsu_rd_en_i, lsu_wr_en_i, lsu_addr_i, lsu_wdata_i, lsu_be_i,
      output lsu_stall_o, lsu_rdata_o,
      input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i, dma_be_i,
      output dma_gnt_o, dma_rvalid_o, dma_rdata_o,
      output dccm_en_o, dccm_we_o, dccm_addr_o, dccm_wdata_o, dccm_be_o,
      input  dccm_rdata_i
   );

   modport master (
      output lsu_rd_en_i, lsu_wr_en_i, lsu_addr_i, lsu_wdata_i, lsu_be_i,
      input  lsu_stall_o, lsu_rdata_o,
      output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i, dma_be_i,
      input  dma_gnt_o, dma_rvalid_o, dma_rdata_o,
      input  dccm_en_o, dccm_we_o, dccm_addr_o, dccm_wdata_o, dccm_be_o,
      output dccm_rdata_i
   );

endinterface

// File: rtl/dccm_port_arb.sv
// Single-port DCCM arbiter: LSU priority, forced DMA grant after STARVE_MAX denials.
// Optional perf counters enabled by defining DCCM_ARB_PERF_EN.
module dccm_port_arb
   import dccm_pkg::*;
#(
   parameter int unsigned AW         = DCCM_AW,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   dccm_port_arb_if.slave   bus
`ifdef DCCM_ARB_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_conflict_o,
   output logic [CNT_W-1:0] perf_force_o
`endif
);

   localparam int unsigned SC_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(STARVE_MAX - 1);

   arb_state_e      r_state, w_state_nxt;
   logic [SC_W-1:0] r_starve, w_starve_nxt;
   owner_e          r_owner, w_owner_nxt;

   logic w_lsu_req, w_dma_req;
   logic w_gnt_lsu, w_gnt_dma, w_stall;

   assign w_lsu_req = bus.lsu_rd_en_i | bus.lsu_wr_en_i;
   assign w_dma_req = bus.dma_req_i;

   always_comb begin
      w_state_nxt  = ST_LSU_PRI;
      w_starve_nxt = '0;
      w_gnt_lsu    = 1'b0;
      w_gnt_dma    = 1'b0;
      w_stall      = 1'b0;
      w_owner_nxt  = OWN_NONE;
      unique case (r_state)
         ST_LSU_PRI: begin
            if (w_lsu_req) begin
               w_gnt_lsu = 1'b1;
               if (w_dma_req) begin
                  if (r_starve == SC_LAST) begin
                     w_state_nxt = ST_DMA_FORCE;
                  end else begin
                     w_starve_nxt = r_starve + 1'b1;
                  end
               end
            end else if (w_dma_req) begin
               w_gnt_dma = 1'b1;
            end
         end
         ST_DMA_FORCE: begin
            if (w_dma_req) begin
               w_gnt_dma = 1'b1;
               w_stall   = w_lsu_req;
            end else if (w_lsu_req) begin
               w_gnt_lsu = 1'b1;
            end
         end
         default: ;
      endcase
      // Grants are gated while reset is held so every output reads 0.
      if (!rst_n) begin
         w_gnt_lsu = 1'b0;
         w_gnt_dma = 1'b0;
         w_stall   = 1'b0;
      end
      if (w_gnt_lsu && !bus.lsu_wr_en_i) begin
         w_owner_nxt = OWN_LSU;
      end else if (w_gnt_dma && !bus.dma_we_i) begin
         w_owner_nxt = OWN_DMA;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_LSU_PRI;
         r_starve <= '0;
         r_owner  <= OWN_NONE;
      end else begin
         r_state  <= w_state_nxt;
         r_starve <= w_starve_nxt;
         r_owner  <= w_owner_nxt;
      end
   end

   always_comb begin
      bus.dccm_en_o    = 1'b0;
      bus.dccm_we_o    = 1'b0;
      bus.dccm_addr_o  = '0;
      bus.dccm_wdata_o = '0;
      bus.dccm_be_o    = '0;
      if (w_gnt_lsu) begin
         bus.dccm_en_o    = 1'b1;
         bus.dccm_we_o    = bus.lsu_wr_en_i;
         bus.dccm_addr_o  = bus.lsu_addr_i[AW+1:2];
         bus.dccm_wdata_o = bus.lsu_wdata_i;
         bus.dccm_be_o    = bus.lsu_wr_en_i ? bus.lsu_be_i : '0;
      end else if (w_gnt_dma) begin
         bus.dccm_en_o    = 1'b1;
         bus.dccm_we_o    = bus.dma_we_i;
         bus.dccm_addr_o  = bus.dma_addr_i[AW+1:2];
         bus.dccm_wdata_o = bus.dma_wdata_i;
         bus.dccm_be_o    = bus.dma_we_i ? bus.dma_be_i : '0;
      end
   end

   assign bus.lsu_stall_o  = w_stall;
   assign bus.dma_gnt_o    = w_gnt_dma;
   assign bus.lsu_rdata_o  = (r_owner == OWN_LSU) ? bus.dccm_rdata_i : '0;
   assign bus.dma_rvalid_o = (r_owner == OWN_DMA);
   assign bus.dma_rdata_o  = (r_owner == OWN_DMA) ? bus.dccm_rdata_i : '0;

`ifdef DCCM_ARB_PERF_EN
   logic [CNT_W-1:0] r_perf_conflict, r_perf_force;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_conflict <= '0;
         r_perf_force    <= '0;
      end else begin
         if (w_lsu_req && w_dma_req && (r_perf_conflict != '1)) begin
            r_perf_conflict <= r_perf_conflict + 1'b1;
         end
         if ((r_state == ST_DMA_FORCE) && w_dma_req && (r_perf_force != '1)) begin
            r_perf_force <= r_perf_force + 1'b1;
         end
      end
   end

   assign perf_conflict_o = r_perf_conflict;
   assign perf_force_o    = r_perf_force;
`endif

`ifndef SYNTHESIS
   a_lsu_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.lsu_rd_en_i && bus.lsu_wr_en_i))
      else $error("LSU load and store requested together; store takes precedence");
`endif

endmodule

// File: tb/tb_dccm_port_arb.sv
// Scoreboard bench for dccm_port_arb: directed scenarios plus random LSU/DMA traffic.
module tb_dccm_port_arb;
   import dccm_pkg::*;

   localparam int unsigned AW = 16;
   localparam int unsigned SM = 4;

   typedef struct {
      bit          rst;
      bit          lrd;
      bit          lwr;
      logic [31:0] laddr;
      logic [31:0] lwd;
      logic [3:0]  lbe;
      bit          dreq;
      bit          dwe;
      logic [31:0] daddr;
      logic [31:0] dwd;
      logic [3:0]  dbe;
   } stim_t;

   typedef struct {
      logic          stall;
      logic          gnt;
      logic          en;
      logic          we;
      logic [AW-1:0] addr;
      logic [3:0]    be;
      logic [31:0]   wdata;
      logic [31:0]   lrd;
      logic          rv;
      logic [31:0]   drd;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dccm_port_arb_if #(.AW(AW)) bus ();

`ifdef DCCM_ARB_PERF_EN
   logic [15:0] perf_conflict, perf_force;
`endif

   dccm_port_arb #(.AW(AW), .STARVE_MAX(SM), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
`ifdef DCCM_ARB_PERF_EN
      ,
      .perf_conflict_o (perf_conflict),
      .perf_force_o    (perf_force)
`endif
   );

   function automatic logic [31:0] init_word(input int unsigned i);
      return (i == 4) ? 32'hDEAD_BEEF : (32'h1000_0000 + i * 32'h0001_0101);
   endfunction

   // SRAM macro stand-in, acting on whatever the DUT presents.
   logic [31:0] sram [64];
   logic        sram_init = 1'b1;
   always @(posedge clk) begin
      if (sram_init) begin
         for (int i = 0; i < 64; i++) sram[i] <= init_word(i);
      end else if (bus.dccm_en_o) begin
         if (bus.dccm_we_o) begin
            for (int b = 0; b < 4; b++)
               if (bus.dccm_be_o[b]) sram[bus.dccm_addr_o[5:0]][b*8 +: 8] <= bus.dccm_wdata_o[b*8 +: 8];
         end else begin
            bus.dccm_rdata_i <= sram[bus.dccm_addr_o[5:0]];
         end
      end
   end

   // Reference model state.
   logic [31:0] ref_mem [64];
   int unsigned deny_run = 0;
   int unsigned prev_owner = 0;
   logic [31:0] prev_data = '0;

   exp_t exp_q[$];
   int total = 0;
   int bad = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
      end
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("lsu_stall", 32'(bus.lsu_stall_o), 32'(e.stall));
            chk("dma_gnt", 32'(bus.dma_gnt_o), 32'(e.gnt));
            chk("dccm_en", 32'(bus.dccm_en_o), 32'(e.en));
            chk("dccm_we", 32'(bus.dccm_we_o), 32'(e.we));
            chk("dccm_addr", 32'(bus.dccm_addr_o), 32'(e.addr));
            chk("dccm_be", 32'(bus.dccm_be_o), 32'(e.be));
            if (e.we) chk("dccm_wdata", bus.dccm_wdata_o, e.wdata);
            chk("lsu_rdata", bus.lsu_rdata_o, e.lrd);
            chk("dma_rvalid", 32'(bus.dma_rvalid_o), 32'(e.rv));
            chk("dma_rdata", bus.dma_rdata_o, e.drd);
         end
      end
   end

   // One clock of stimulus; the expected response is pushed for the monitor.
   task automatic cycle(input stim_t s, output bit dma_won);
      exp_t e;
      int unsigned who;
      bit lsu_req;
      logic [31:0] a;
      @(posedge clk);
      #1;
      rst_n           = !s.rst;
      bus.lsu_rd_en_i = s.lrd;
      bus.lsu_wr_en_i = s.lwr;
      bus.lsu_addr_i  = s.laddr;
      bus.lsu_wdata_i = s.lwd;
      bus.lsu_be_i    = s.lbe;
      bus.dma_req_i   = s.dreq;
      bus.dma_we_i    = s.dwe;
      bus.dma_addr_i  = s.daddr;
      bus.dma_wdata_i = s.dwd;
      bus.dma_be_i    = s.dbe;

      e = '{stall: 1'b0, gnt: 1'b0, en: 1'b0, we: 1'b0, addr: '0, be: '0,
            wdata: '0, lrd: '0, rv: 1'b0, drd: '0};
      dma_won = 1'b0;
      if (s.rst) begin
         deny_run   = 0;
         prev_owner = 0;
         exp_q.push_back(e);
         return;
      end
      e.lrd = (prev_owner == 1) ? prev_data : '0;
      e.rv  = (prev_owner == 2);
      e.drd = (prev_owner == 2) ? prev_data : '0;

      lsu_req = s.lrd | s.lwr;
      if (deny_run >= SM) begin
         who      = s.dreq ? 2 : (lsu_req ? 1 : 0);
         e.stall  = s.dreq & lsu_req;
         deny_run = 0;
      end else if (lsu_req) begin
         who      = 1;
         deny_run = s.dreq ? deny_run + 1 : 0;
      end else begin
         who      = s.dreq ? 2 : 0;
         deny_run = 0;
      end

      prev_owner = 0;
      if (who != 0) begin
         a       = (who == 1) ? s.laddr : s.daddr;
         e.en    = 1'b1;
         e.we    = (who == 1) ? s.lwr : s.dwe;
         e.addr  = a[AW+1:2];
         e.wdata = (who == 1) ? s.lwd : s.dwd;
         e.be    = e.we ? ((who == 1) ? s.lbe : s.dbe) : 4'h0;
         if (e.we) begin
            for (int b = 0; b < 4; b++)
               if (e.be[b]) ref_mem[a[7:2]][b*8 +: 8] = e.wdata[b*8 +: 8];
         end else begin
            prev_owner = who;
            prev_data  = ref_mem[a[7:2]];
         end
      end
      e.gnt   = (who == 2);
      dma_won = (who == 2);
      exp_q.push_back(e);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] r;
      r = $urandom;
      return (r & 32'hFFFC_0000) | (32'($urandom_range(0, 63)) << 2) | (r & 32'h3);
   endfunction

   function automatic stim_t idle();
      return '{rst: 1'b0, lrd: 1'b0, lwr: 1'b0, laddr: '0, lwd: '0, lbe: '0,
               dreq: 1'b0, dwe: 1'b0, daddr: '0, dwd: '0, dbe: '0};
   endfunction

   initial begin : driver
      stim_t s, pend_s;
      bit g, pend;
      int unsigned r;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

      // Reset, including a cycle with live requests that must stay masked.
      s = idle(); s.rst = 1'b1;
      cycle(s, g);
      s.lrd = 1'b1; s.laddr = 32'h10; s.dreq = 1'b1; s.daddr = 32'h20;
      cycle(s, g);
      sram_init = 1'b0;
      cycle(idle(), g);

      // LSU-only load of word 4.
      s = idle(); s.lrd = 1'b1; s.laddr = 32'h10;
      cycle(s, g);
      cycle(idle(), g);

      // DMA-only full-word write.
      s = idle(); s.dreq = 1'b1; s.dwe = 1'b1; s.daddr = 32'h20; s.dwd = 32'h1234_5678; s.dbe = 4'hF;
      cycle(s, g);

      // Continuous LSU loads against a held DMA read: forced grant on the 5th cycle.
      s = idle(); s.lrd = 1'b1; s.laddr = 32'h0; s.dreq = 1'b1; s.daddr = 32'h24;
      for (int k = 0; k < 6; k++) begin
         s.laddr = 32'(k * 4);
         cycle(s, g);
         if (g) s.dreq = 1'b0;
      end
      cycle(idle(), g);

      // Alternating owners back-to-back.
      s = idle(); s.lrd = 1'b1; s.laddr = 32'h0;
      cycle(s, g);
      s = idle(); s.dreq = 1'b1; s.daddr = 32'h4;
      cycle(s, g);
      cycle(idle(), g);

      // DMA withdraws in the forced cycle; LSU proceeds without a stall.
      s = idle(); s.lrd = 1'b1; s.laddr = 32'h8; s.dreq = 1'b1; s.daddr = 32'hC;
      for (int k = 0; k < 4; k++) cycle(s, g);
      s.dreq = 1'b0;
      cycle(s, g);
      s.dreq = 1'b1;
      for (int k = 0; k < 5; k++) cycle(s, g);
      cycle(idle(), g);

      // Random traffic; DMA holds a request until granted, with rare withdrawals.
      pend = 1'b0;
      pend_s = idle();
      for (int n = 0; n < 600; n++) begin
         if (!pend && ($urandom_range(0, 2) == 0)) begin
            pend         = 1'b1;
            pend_s.dwe   = 1'($urandom_range(0, 1));
            pend_s.daddr = rand_addr();
            pend_s.dwd   = $urandom;
            pend_s.dbe   = 4'($urandom);
         end else if (pend && ($urandom_range(0, 19) == 0)) begin
            pend = 1'b0;
         end
         s = idle();
         r = $urandom_range(0, 3);
         s.lrd   = (r == 1) || (r == 3);
         s.lwr   = (r == 2);
         s.laddr = rand_addr();
         s.lwd   = $urandom;
         s.lbe   = 4'($urandom);
         s.dreq  = pend;
         s.dwe   = pend_s.dwe;
         s.daddr = pend_s.daddr;
         s.dwd   = pend_s.dwd;
         s.dbe   = pend_s.dbe;
         cycle(s, g);
         if (g) pend = 1'b0;
      end
      cycle(idle(), g);

      // Reset right after a DMA read grant drops the pending read return.
      s = idle(); s.dreq = 1'b1; s.daddr = 32'h10;
      cycle(s, g);
      s = idle(); s.rst = 1'b1; s.lrd = 1'b1; s.laddr = 32'h4;
      cycle(s, g);
      cycle(s, g);
      cycle(idle(), g);
      s = idle(); s.lrd = 1'b1; s.laddr = 32'h10;
      cycle(s, g);
      cycle(idle(), g);

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
